// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one RAM port between two requesters: port 0 (microprocessor
// MAR/MBR path) and port 1 (program loader / DMA). Each access runs
// IDLE -> ACCESS (RAM_LAT cycles with ram_en high) -> DONE (one-cycle ack).
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   reqN/rwN/addrN/wdataN   port N request, direction (1=write), address, data
//   lockN                   port N bus lock, keeps ownership across accesses
//   ackN/rdataN             port N completion pulse and read data
//   ram_en/ram_rw           RAM strobe and direction (1=write)
//   ram_addr/ram_data       RAM address and write data
//   ram_out                 RAM read data
//   grant                   one-hot current owner, 00 when idle
//   busy                    high in ACCESS and DONE
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : 1-bit round-robin pointer breaks ties
//                       undefined : fixed priority, port 0 wins ties
module ram_port_arbiter #(
    parameter int RAM_LAT = 1,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_out,
    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    // Counter value loaded on entry to ACCESS; zero marks the last ACCESS cycle.
    localparam logic [3:0] LAT_LAST = 4'(RAM_LAT - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] cnt_r;
    logic       lock_vld_r;   // a reservation is pending
    logic       lock_own_r;   // port holding the reservation
    logic       lock_hold_s;  // reservation is exercised this IDLE cycle
    logic       pref_s;       // preferred port on a simultaneous request
    logic       win_vld_s;
    logic       win_sel_s;
    logic       owner_s;
    logic       owner_lock_s;

    assign owner_s      = grant[1];
    assign owner_lock_s = owner_s ? lock1 : lock0;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_r;

    // Round-robin pointer: after each DONE, prefer the port that did not own the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            rr_r <= ~owner_s;
        end else begin
            rr_r <= rr_r;
        end
    end

    assign pref_s = rr_r;
`else
    assign pref_s = 1'b0;
`endif

    // Arbitration: an active lock reservation overrides normal priority.
    always_comb begin
        lock_hold_s = 1'b0;
        win_vld_s   = 1'b0;
        win_sel_s   = 1'b0;
        if (lock_vld_r) begin
            if (lock_own_r) begin
                lock_hold_s = req1 & lock1;
            end else begin
                lock_hold_s = req0 & lock0;
            end
        end else begin
            lock_hold_s = 1'b0;
        end
        if (lock_hold_s) begin
            win_vld_s = 1'b1;
            win_sel_s = lock_own_r;
        end else if (req0 && req1) begin
            win_vld_s = 1'b1;
            win_sel_s = pref_s;
        end else if (req0) begin
            win_vld_s = 1'b1;
            win_sel_s = 1'b0;
        end else if (req1) begin
            win_vld_s = 1'b1;
            win_sel_s = 1'b1;
        end else begin
            win_vld_s = 1'b0;
            win_sel_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered datapath: RAM port, grant, counter, acks, read data and lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r      <= 4'd0;
            ram_en     <= 1'b0;
            ram_rw     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            grant      <= 2'b00;
            busy       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            lock_vld_r <= 1'b0;
            lock_own_r <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A reservation not exercised this cycle is released at once.
                    if (!lock_hold_s) begin
                        lock_vld_r <= 1'b0;
                    end else begin
                        lock_vld_r <= lock_vld_r;
                    end
                    if (win_vld_s) begin
                        ram_rw   <= win_sel_s ? rw1 : rw0;
                        ram_addr <= win_sel_s ? addr1 : addr0;
                        ram_data <= win_sel_s ? wdata1 : wdata0;
                        grant    <= win_sel_s ? 2'b10 : 2'b01;
                        ram_en   <= 1'b1;
                        busy     <= 1'b1;
                        cnt_r    <= LAT_LAST;
                    end else begin
                        ram_en <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == 4'd0) begin
                        ram_en <= 1'b0;
                        if (!ram_rw) begin
                            if (owner_s) begin
                                rdata1 <= ram_out;
                            end else begin
                                rdata0 <= ram_out;
                            end
                        end else begin
                            rdata0 <= rdata0;
                        end
                        if (owner_s) begin
                            ack1 <= 1'b1;
                        end else begin
                            ack0 <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    grant      <= 2'b00;
                    busy       <= 1'b0;
                    lock_vld_r <= owner_lock_s;
                    lock_own_r <= owner_s;
                end
                default: begin
                    ram_en <= 1'b0;
                    grant  <= 2'b00;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed stimulus, scoreboard
// queue of expected acks checked by an independent negedge monitor.
module tb_ram_port_arbiter;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, rw0, lock0, ack0;
    logic       req1, rw1, lock1, ack1;
    logic [7:0] addr0, wdata0, rdata0;
    logic [7:0] addr1, wdata1, rdata1;
    logic       ram_en, ram_rw, busy;
    logic [7:0] ram_addr, ram_data, ram_out;
    logic [1:0] grant;

    typedef struct {
        int         port;
        logic [7:0] rd;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         mon_p;
    logic [7:0] shadow [2];
    int         n_chk  = 0;
    int         n_fail = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    ram_port_arbiter #(.RAM_LAT(LAT), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .ack1(ack1), .rdata1(rdata1),
        .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_out(ram_out), .grant(grant), .busy(busy)
    );

    // RAM model: preloaded location 0x3C = 0xA5, writes while ram_en && ram_rw.
    assign ram_out = mem[ram_addr];
    always @(posedge clk) begin
        if (!rst_n) mem[8'h3C] <= 8'hA5;
        else if (ram_en && ram_rw) mem[ram_addr] <= ram_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expectation and checks owner and read data.
    always @(negedge clk) begin
        if (rst_n && (ack0 || ack1)) begin
            if (ack0 && ack1) begin
                n_chk++; n_fail++;
                $display("FAIL ack_onehot: got ack0=1 ack1=1 required a single ack");
            end else if (sb_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b required no ack", ack0, ack1);
            end else begin
                mon_e = sb_q.pop_front();
                mon_p = ack1 ? 1 : 0;
                check("sb_port", mon_p, mon_e.port);
                check("sb_rdata", (mon_p == 1) ? rdata1 : rdata0, mon_e.rd);
                check("sb_other_rdata", (mon_p == 1) ? rdata0 : rdata1, shadow[1 - mon_p]);
                shadow[mon_e.port] = mon_e.rd;
            end
        end
    end

    task automatic wait_ack(output int port, output bit ok);
        port = -1;
        ok   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (ack0 || ack1) begin
                port = ack1 ? 1 : 0;
                ok   = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL ack_timeout: got no ack in 64 cycles required an ack");
        end
    endtask

    task automatic wait_grant(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (grant != 2'b00) begin
                g = grant;
                break;
            end
        end
    endtask

    task automatic set_port(input int port, input logic rw, input logic [7:0] a, input logic [7:0] d);
        if (port == 0) begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = d; end
        else           begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = d; end
    endtask

    // Single access with cycle-accurate checks on grant, ram_en and ack timing.
    task automatic timed_access(input int port, input logic rw, input logic [7:0] a,
                                input logic [7:0] d, input logic [7:0] exp_rd);
        logic [1:0] g_exp;
        g_exp = (port == 1) ? 2'b10 : 2'b01;
        set_port(port, rw, a, d);
        sb_q.push_back('{port, exp_rd});
        @(posedge clk); #1;
        check("start_grant", grant, g_exp);
        check("start_ram_en", ram_en, 1'b1);
        check("start_busy", busy, 1'b1);
        check("start_addr", ram_addr, a);
        check("start_rw", ram_rw, rw);
        if (rw) check("start_data", ram_data, d);
        for (int i = 1; i < LAT; i++) begin
            @(posedge clk); #1;
            check("acc_ram_en", ram_en, 1'b1);
            check("acc_addr", ram_addr, a);
            check("acc_no_ack", {ack1, ack0}, 2'b00);
        end
        @(posedge clk); #1;
        check("done_ack", {ack1, ack0}, g_exp);
        check("done_ram_en", ram_en, 1'b0);
        check("done_busy", busy, 1'b1);
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
        @(posedge clk); #1;
        check("idle_grant", grant, 2'b00);
        check("idle_busy", busy, 1'b0);
        check("idle_ack", {ack1, ack0}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         p;
        bit         ok;
        logic [1:0] g;
        time        t_prev;
        int         exp_port [3];
        logic [7:0] exp_rd   [3];

        rst_n = 1'b0;
        req0 = 1'b0; rw0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00; lock0 = 1'b0;
        req1 = 1'b0; rw1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00; lock1 = 1'b0;
        shadow[0] = 8'h00; shadow[1] = 8'h00;
        t_prev = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {ack1, ack0}, 2'b00);
        check("rst_ram_en", ram_en, 1'b0);
        check("rst_ram_rw", ram_rw, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_ram_addr", ram_addr, 8'h00);
        check("rst_ram_data", ram_data, 8'h00);
        check("rst_rdata0", rdata0, 8'h00);
        check("rst_rdata1", rdata1, 8'h00);
        rst_n = 1'b1;

        // Single read on port 0, then write and read-back on port 1.
        timed_access(0, 1'b0, 8'h3C, 8'h00, 8'hA5);
        timed_access(1, 1'b1, 8'h10, 8'h5A, 8'h00);
        timed_access(1, 1'b0, 8'h10, 8'h00, 8'h5A);

        // Simultaneous requests held across acks; port 0 alternates its address.
`ifdef ARB_ROUND_ROBIN_EN
        exp_port = '{0, 1, 0};
        exp_rd   = '{8'hA5, 8'h5A, 8'h5A};
`else
        exp_port = '{0, 0, 0};
        exp_rd   = '{8'hA5, 8'h5A, 8'hA5};
`endif
        for (int k = 0; k < 3; k++) sb_q.push_back('{exp_port[k], exp_rd[k]});
        set_port(0, 1'b0, 8'h3C, 8'h00);
        set_port(1, 1'b0, 8'h10, 8'h00);
        for (int k = 0; k < 3; k++) begin
            wait_ack(p, ok);
            check("simul_grant", grant, (exp_port[k] == 1) ? 2'b10 : 2'b01);
            if (k > 0) check("b2b_gap", int'($time - t_prev), (LAT + 2) * 10);
            t_prev = $time;
            if (p == 0) addr0 = (addr0 == 8'h3C) ? 8'h10 : 8'h3C;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("simul_idle_grant", grant, 2'b00);

        // Lock: port 1 keeps the bus ahead of a waiting port 0.
        lock1 = 1'b1;
        set_port(1, 1'b0, 8'h10, 8'h00);
        sb_q.push_back('{1, 8'h5A});
        wait_grant(g);
        check("lock_first_grant", g, 2'b10);
        set_port(0, 1'b0, 8'h3C, 8'h00);
        sb_q.push_back('{1, 8'h5A});
        sb_q.push_back('{0, 8'hA5});
        wait_ack(p, ok);
        check("lock_first_ack", p, 1);
        @(posedge clk);
        wait_grant(g);
        check("lock_second_grant", g, 2'b10);
        lock1 = 1'b0;
        wait_ack(p, ok);
        check("lock_second_ack", p, 1);
        req1 = 1'b0;
        wait_ack(p, ok);
        check("lock_release_ack", p, 0);
        req0 = 1'b0;
        repeat (2) @(posedge clk);

        // Reset in the middle of ACCESS aborts the access without an ack.
        #1;
        set_port(0, 1'b0, 8'h3C, 8'h00);
        @(posedge clk); #1;
        check("abort_start_grant", grant, 2'b01);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_ram_en", ram_en, 1'b0);
        check("abort_grant", grant, 2'b00);
        check("abort_busy", busy, 1'b0);
        req0 = 1'b0;
        shadow[0] = 8'h00;
        shadow[1] = 8'h00;
        rst_n = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("abort_rdata0", rdata0, 8'h00);
        timed_access(0, 1'b0, 8'h3C, 8'h00, 8'hA5);

        repeat (4) @(posedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
